// File: rtl/spram_arb_pkg.sv
`default_nettype none
// ============================================================================
// spram_arb_pkg : shared types, widths and grant function for the SPRAM arbiter
// Revision      : 1.0 - initial release
// ============================================================================
package spram_arb_pkg;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } req_id_e;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int MEM_AW = 14;

    // Returns {m1_gnt, m0_gnt}. A lock only matters under contention, and only
    // for the requester that owns last_gnt.
    function automatic logic [1:0] arb_grant(
        input logic    req0,
        input logic    req1,
        input logic    lock0,
        input logic    lock1,
        input req_id_e last,
        input logic    lock_en
    );
        logic [1:0] g;
        g = 2'b00;
        if (req0 && !req1) begin
            g = 2'b01;
        end else if (req1 && !req0) begin
            g = 2'b10;
        end else if (req0 && req1) begin
            if (lock_en && (last == M0) && lock0) begin
                g = 2'b01;
            end else if (lock_en && (last == M1) && lock1) begin
                g = 2'b10;
            end else if (last == M0) begin
                g = 2'b10;
            end else begin
                g = 2'b01;
            end
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spram64k.sv
`default_nettype none
// ============================================================================
// spram64k : 16K x 32 single-port RAM (64 KB), byte-write, registered read
// Revision : 1.0 - initial release
// ============================================================================
module spram64k
    import spram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [MASK_W-1:0] bmsk,
    input  logic [MEM_AW-1:0] a,
    input  logic [DATA_W-1:0] vi,
    output logic [DATA_W-1:0] vo
);

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
    logic [DATA_W-1:0] vo_q;

    // Read data is captured at the grant edge, so a write on the following
    // cycle cannot disturb it (read-before-write).
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < MASK_W; b++) begin
                    if (bmsk[b]) begin
                        mem[a][8*b +: 8] <= vi[8*b +: 8];
                    end
                end
            end else begin
                vo_q <= mem[a];
            end
        end
    end

    assign vo = vo_q;

endmodule
`default_nettype wire

// File: rtl/spram_arb.sv
`default_nettype none
// ============================================================================
// spram_arb : two-requester round-robin/lock arbiter in front of one spram64k
// Revision  : 1.0 - initial release
// ============================================================================
module spram_arb
    import spram_arb_pkg::*;
#(
    parameter int LOCK_EN = 1,
    parameter int FIRST   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [MASK_W-1:0] m0_bmsk,
    input  logic [ADDR_W-1:0] m0_a,
    input  logic [DATA_W-1:0] m0_vi,
    input  logic              m0_lock,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [MASK_W-1:0] m1_bmsk,
    input  logic [ADDR_W-1:0] m1_a,
    input  logic [DATA_W-1:0] m1_vi,
    input  logic              m1_lock,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvld,
    output logic              m1_rvld,
    output logic [DATA_W-1:0] vo,
    output logic              busy
);

    // Reset last_gnt to the requester that must lose the first contention.
    localparam req_id_e LAST_RST = (FIRST == 0) ? M1 : M0;

    req_id_e           last_gnt_q, last_gnt_d;
    logic              m0_rvld_q, m0_rvld_d;
    logic              m1_rvld_q, m1_rvld_d;
    logic              busy_q, busy_d;
    logic [MEM_AW-1:0] mem_a_q, mem_a_d;
    logic [1:0]        gnt;
    logic              mem_en, mem_we;
    logic [MASK_W-1:0] mem_bmsk;
    logic [DATA_W-1:0] mem_vi;
    logic              unused_a_hi;

    always_comb begin
        gnt        = 2'b00;
        last_gnt_d = last_gnt_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_bmsk   = '0;
        mem_vi     = '0;
        mem_a_d    = mem_a_q;
        m0_rvld_d  = 1'b0;
        m1_rvld_d  = 1'b0;
        if (rst_n) begin
            gnt = arb_grant(m0_req, m1_req, m0_lock, m1_lock, last_gnt_q, LOCK_EN != 0);
        end
        if (gnt[0]) begin
            last_gnt_d = M0;
            mem_en     = 1'b1;
            mem_we     = m0_we;
            mem_bmsk   = m0_bmsk;
            mem_vi     = m0_vi;
            mem_a_d    = m0_a[MEM_AW-1:0];
            m0_rvld_d  = ~m0_we;
        end else if (gnt[1]) begin
            last_gnt_d = M1;
            mem_en     = 1'b1;
            mem_we     = m1_we;
            mem_bmsk   = m1_bmsk;
            mem_vi     = m1_vi;
            mem_a_d    = m1_a[MEM_AW-1:0];
            m1_rvld_d  = ~m1_we;
        end
        busy_d = m0_rvld_d | m1_rvld_d;
    end

    // The top two address bits alias onto the 16K-word array.
    assign unused_a_hi = ^{m0_a[ADDR_W-1:MEM_AW], m1_a[ADDR_W-1:MEM_AW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= LAST_RST;
            m0_rvld_q  <= 1'b0;
            m1_rvld_q  <= 1'b0;
            busy_q     <= 1'b0;
            mem_a_q    <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            m0_rvld_q  <= m0_rvld_d;
            m1_rvld_q  <= m1_rvld_d;
            busy_q     <= busy_d;
            mem_a_q    <= mem_a_d;
        end
    end

    spram64k u_mem (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .bmsk (mem_bmsk),
        .a    (mem_a_d),
        .vi   (mem_vi),
        .vo   (vo)
    );

    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];
    assign m0_rvld = m0_rvld_q;
    assign m1_rvld = m1_rvld_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire
